// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin arbiter in front of mux_4_1.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_4_1.sv
// Combinational 4:1 data mux; only the selected input reaches y.
module mux_4_1 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the mux_4_1 select; registers the granted word
// and hands it downstream under valid/ready.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       d0,
  input  logic [W-1:0]       d1,
  input  logic [W-1:0]       d2,
  input  logic [W-1:0]       d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [W-1:0]       y,
  output logic               y_valid,
  input  logic               y_ready,
  output arb_state_t         state_dbg
);
  // Handshake: y is transferred on any cycle where y_valid & y_ready; y_valid
  // stays high and y stays stable until then. A new word loads in the same
  // cycle the old one leaves, so throughput is one word per cycle.

  arb_state_t     state_q;
  sel_t           sel_q;
  sel_t           last_q;
  logic [W-1:0]   y_q;
  logic           y_valid_q;
  sel_t           winner;
  logic [W-1:0]   mux_y;
  logic           load;

  // Searches last+4 down to last+1 so the closest pending index after last wins.
  function automatic sel_t rr_pick(input logic [NUM_REQ-1:0] r, input sel_t last);
    sel_t idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + sel_t'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(req, last_q);
  assign load   = (|req) && ((state_q == IDLE) || (y_valid_q && y_ready));

  mux_4_1 #(.W(W)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (winner),
    .y   (mux_y)
  );

  always_comb begin
    gnt = '0;
    if (load && !rst) gnt[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sel_q     <= '0;
      last_q    <= sel_t'(NUM_REQ - 1);
    end else if (load) begin
      state_q   <= BUSY;
      y_q       <= mux_y;
      y_valid_q <= 1'b1;
      sel_q     <= winner;
      last_q    <= winner;
    end else if (y_valid_q && y_ready) begin
      state_q   <= IDLE;
      y_valid_q <= 1'b0;
    end
  end

  assign sel       = sel_q;
  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign state_dbg = state_q;
endmodule
